ysyx_23060136_idu_scoreboard: RTL and testbench

In-order issue controller between IDU and EXU. It tracks in-flight GPR writes with per-register pending counters and holds issue on RAW hazards, a full pipeline, or a serializing instruction that is waiting to drain. It also latches the halt condition. It sits beside the decoder and GPR file, consumes WB retire information, and gates the IDU→EXU valid/ready handshake.

---
 rtl/ysyx_23060136_idu_scoreboard.sv | 169 ++++++++++++++++
 tb/tb_ysyx_23060136_idu_scoreboard.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060136_idu_scoreboard.sv
// ysyx_23060136_idu_scoreboard
// ----------------------------------------------------------------------------
// In-order issue controller sitting between IDU and EXU. Tracks in-flight GPR
// writes with one pending counter per architectural register (x0 excluded),
// and holds issue on RAW hazards, a full pipeline, a serializing instruction
// waiting for the pipeline to drain, or after a halt instruction has issued.
//
// Optional feature macro: YSYX_23060136_SB_RETIRE_BYPASS_EN
//   When defined, a retire in the current cycle is subtracted from the
//   pending/in-flight counts before the RAW and serialize checks, so the
//   final retire of a blocking writer unblocks issue in that same cycle.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   IDU_i_*             decoded instruction fields and valid
//   EXU_i_ready         EXU accepts this cycle
//   IDU_o_valid/ready   gated handshake towards EXU / back to IDU register
//   WB_i_retire/rd/RegWr  retire information from write-back
//   IDU_o_stall_*       stall cause flags (qualified with IDU_i_valid)
//   IDU_o_inflight      issued-but-unretired count
//   IDU_o_halted        halted and fully drained
//   IDU_o_sb_err        sticky counter-underflow error
// ----------------------------------------------------------------------------
module ysyx_23060136_idu_scoreboard #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IDU_i_valid,
  input  logic [4:0]       IDU_i_rs1,
  input  logic [4:0]       IDU_i_rs2,
  input  logic             IDU_i_use_rs1,
  input  logic             IDU_i_use_rs2,
  input  logic [4:0]       IDU_i_rd,
  input  logic             IDU_i_write_gpr,
  input  logic             IDU_i_serialize,
  input  logic             IDU_i_system_halt,
  input  logic             EXU_i_ready,
  output logic             IDU_o_valid,
  output logic             IDU_o_ready,
  input  logic             WB_i_retire,
  input  logic [4:0]       WB_i_rd,
  input  logic             WB_i_RegWr,
  output logic             IDU_o_stall_raw,
  output logic             IDU_o_stall_full,
  output logic             IDU_o_stall_ser,
  output logic [CNT_W-1:0] IDU_o_inflight,
  output logic             IDU_o_halted,
  output logic             IDU_o_sb_err
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] inflight_reg, inflight_next;
  logic             sb_err_reg;

  // Per-register hazard view and underflow detection; bit 0 (x0) stays 0.
  logic [31:0] busy;
  logic [31:0] cnt_underflow;
  logic        issue;

  assign busy[0]          = 1'b0;
  assign cnt_underflow[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_gpr
      localparam logic [4:0] IDX = 5'(gi);
      logic [CNT_W-1:0] cnt_reg;
      logic             inc;
      logic             dec;

      assign inc = issue & IDU_i_write_gpr & (IDU_i_rd == IDX);
      assign dec = WB_i_retire & WB_i_RegWr & (WB_i_rd == IDX);

      // A decrement of an empty counter is dropped (and flagged), so a
      // coincident increment still lands.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_reg <= '0;
        end else if (inc && !(dec && cnt_reg != '0)) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end else if (!inc && dec && cnt_reg != '0) begin
          cnt_reg <= cnt_reg - CNT_W'(1);
        end
      end

`ifdef YSYX_23060136_SB_RETIRE_BYPASS_EN
      assign busy[gi] = (cnt_reg != '0) && !(dec && cnt_reg == CNT_W'(1));
`else
      assign busy[gi] = (cnt_reg != '0);
`endif
      assign cnt_underflow[gi] = dec && (cnt_reg == '0);
    end
  endgenerate

  logic raw, full, ser, block, inflight_busy;

`ifdef YSYX_23060136_SB_RETIRE_BYPASS_EN
  assign inflight_busy = (inflight_reg != '0) &&
                         !(WB_i_retire && inflight_reg == CNT_W'(1));
`else
  assign inflight_busy = (inflight_reg != '0);
`endif

  assign raw   = (IDU_i_use_rs1 & busy[IDU_i_rs1]) |
                 (IDU_i_use_rs2 & busy[IDU_i_rs2]);
  assign full  = (inflight_reg == CNT_W'(DEPTH));
  assign ser   = IDU_i_serialize & inflight_busy;
  assign block = raw | full | ser | (state_reg == ST_HALTED);

  assign IDU_o_valid      = IDU_i_valid & ~block;
  assign IDU_o_ready      = ~block & EXU_i_ready;
  assign issue            = IDU_o_valid & EXU_i_ready;
  assign IDU_o_stall_raw  = raw & IDU_i_valid;
  assign IDU_o_stall_full = full & IDU_i_valid;
  assign IDU_o_stall_ser  = ser & IDU_i_valid;
  assign IDU_o_inflight   = inflight_reg;
  assign IDU_o_halted     = (state_reg == ST_HALTED) && (inflight_reg == '0);
  assign IDU_o_sb_err     = sb_err_reg;

  logic retire_dec;
  assign retire_dec = WB_i_retire && (inflight_reg != '0);

  always_comb begin
    inflight_next = inflight_reg;
    if (issue && !retire_dec) begin
      inflight_next = inflight_reg + CNT_W'(1);
    end else if (!issue && retire_dec) begin
      inflight_next = inflight_reg - CNT_W'(1);
    end
  end

  // A halt that issues while still draining is honoured too, so it is
  // never lost to the DRAIN->RUN transition.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN: begin
        if (issue && IDU_i_system_halt)  state_next = ST_HALTED;
        else if (IDU_i_valid && ser)     state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (issue && IDU_i_system_halt)  state_next = ST_HALTED;
        else if (inflight_reg == '0)     state_next = ST_RUN;
      end
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_RUN;
      inflight_reg <= '0;
      sb_err_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= inflight_next;
      if ((WB_i_retire && inflight_reg == '0) || (|cnt_underflow)) begin
        sb_err_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060136_idu_scoreboard.sv
// Self-checking bench for ysyx_23060136_idu_scoreboard: directed scenarios
// followed by a randomized run against an in-order queue model of the
// issued-but-unretired instructions.
module tb_ysyx_23060136_idu_scoreboard;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst;
  logic IDU_i_valid, IDU_i_use_rs1, IDU_i_use_rs2, IDU_i_write_gpr;
  logic IDU_i_serialize, IDU_i_system_halt, EXU_i_ready;
  logic [4:0] IDU_i_rs1, IDU_i_rs2, IDU_i_rd, WB_i_rd;
  logic WB_i_retire, WB_i_RegWr;
  logic IDU_o_valid, IDU_o_ready, IDU_o_stall_raw, IDU_o_stall_full;
  logic IDU_o_stall_ser, IDU_o_halted, IDU_o_sb_err;
  logic [CNT_W-1:0] IDU_o_inflight;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_23060136_idu_scoreboard #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .IDU_i_valid(IDU_i_valid), .IDU_i_rs1(IDU_i_rs1), .IDU_i_rs2(IDU_i_rs2),
    .IDU_i_use_rs1(IDU_i_use_rs1), .IDU_i_use_rs2(IDU_i_use_rs2),
    .IDU_i_rd(IDU_i_rd), .IDU_i_write_gpr(IDU_i_write_gpr),
    .IDU_i_serialize(IDU_i_serialize), .IDU_i_system_halt(IDU_i_system_halt),
    .EXU_i_ready(EXU_i_ready), .IDU_o_valid(IDU_o_valid), .IDU_o_ready(IDU_o_ready),
    .WB_i_retire(WB_i_retire), .WB_i_rd(WB_i_rd), .WB_i_RegWr(WB_i_RegWr),
    .IDU_o_stall_raw(IDU_o_stall_raw), .IDU_o_stall_full(IDU_o_stall_full),
    .IDU_o_stall_ser(IDU_o_stall_ser), .IDU_o_inflight(IDU_o_inflight),
    .IDU_o_halted(IDU_o_halted), .IDU_o_sb_err(IDU_o_sb_err)
  );

  typedef struct {
    bit       w;
    bit [4:0] rd;
  } ent_t;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    IDU_i_valid = 0; IDU_i_rs1 = 0; IDU_i_rs2 = 0; IDU_i_use_rs1 = 0; IDU_i_use_rs2 = 0;
    IDU_i_rd = 0; IDU_i_write_gpr = 0; IDU_i_serialize = 0; IDU_i_system_halt = 0;
    EXU_i_ready = 1; WB_i_retire = 0; WB_i_rd = 0; WB_i_RegWr = 0;
  endtask

  task automatic test_reset;
    rst = 0; idle();
    IDU_i_valid = 1; IDU_i_use_rs1 = 1; IDU_i_rs1 = 5;
    repeat (2) tick();
    checks++; if (IDU_o_valid !== 1'b1) begin errors++; $display("FAIL reset_valid got %b exp 1", IDU_o_valid); end
    checks++; if (IDU_o_inflight !== 0) begin errors++; $display("FAIL reset_inflight got %0d exp 0", IDU_o_inflight); end
    checks++; if (IDU_o_halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", IDU_o_halted); end
    checks++; if (IDU_o_sb_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", IDU_o_sb_err); end
    $display("reset: valid=%b inflight=%0d", IDU_o_valid, IDU_o_inflight);
    IDU_i_valid = 0; rst = 1;
    tick();
  endtask

  task automatic test_basic_issue;
    IDU_i_valid = 1; IDU_i_use_rs1 = 1; IDU_i_rs1 = 5; #1;
    checks++; if (IDU_o_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", IDU_o_valid); end
    checks++; if (IDU_o_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b exp 1", IDU_o_ready); end
    tick(); idle(); #1;
    checks++; if (IDU_o_inflight !== 1) begin errors++; $display("FAIL basic_inflight got %0d exp 1", IDU_o_inflight); end
    $display("basic issue: inflight=%0d", IDU_o_inflight);
    WB_i_retire = 1; tick(); idle(); #1;
    checks++; if (IDU_o_inflight !== 0) begin errors++; $display("FAIL basic_retire got %0d exp 0", IDU_o_inflight); end
  endtask

  task automatic test_raw;
    IDU_i_valid = 1; IDU_i_write_gpr = 1; IDU_i_rd = 5; tick();
    IDU_i_write_gpr = 0; IDU_i_rd = 0; IDU_i_use_rs1 = 1; IDU_i_rs1 = 5; #1;
    checks++; if (IDU_o_stall_raw !== 1'b1) begin errors++; $display("FAIL raw_stall got %b exp 1", IDU_o_stall_raw); end
    checks++; if (IDU_o_valid !== 1'b0) begin errors++; $display("FAIL raw_valid got %b exp 0", IDU_o_valid); end
    tick();
    checks++; if (IDU_o_valid !== 1'b0) begin errors++; $display("FAIL raw_hold got %b exp 0", IDU_o_valid); end
    WB_i_retire = 1; WB_i_RegWr = 1; WB_i_rd = 5; #1;
`ifdef YSYX_23060136_SB_RETIRE_BYPASS_EN
    checks++; if (IDU_o_valid !== 1'b1) begin errors++; $display("FAIL raw_bypass got %b exp 1", IDU_o_valid); end
    tick(); idle();
`else
    checks++; if (IDU_o_valid !== 1'b0) begin errors++; $display("FAIL raw_nobypass got %b exp 0", IDU_o_valid); end
    tick(); WB_i_retire = 0; WB_i_RegWr = 0; #1;
    checks++; if (IDU_o_valid !== 1'b1) begin errors++; $display("FAIL raw_release got %b exp 1", IDU_o_valid); end
    tick(); idle();
`endif
    #1;
    checks++; if (IDU_o_inflight !== 1) begin errors++; $display("FAIL raw_inflight got %0d exp 1", IDU_o_inflight); end
    $display("raw: dependent issued, inflight=%0d", IDU_o_inflight);
    WB_i_retire = 1; tick(); idle();
  endtask

  task automatic test_full;
    IDU_i_valid = 1; repeat (4) tick(); #1;
    checks++; if (IDU_o_inflight !== 4) begin errors++; $display("FAIL full_inflight got %0d exp 4", IDU_o_inflight); end
    checks++; if (IDU_o_stall_full !== 1'b1) begin errors++; $display("FAIL full_stall got %b exp 1", IDU_o_stall_full); end
    checks++; if (IDU_o_valid !== 1'b0 || IDU_o_ready !== 1'b0) begin errors++; $display("FAIL full_block got %b%b exp 00", IDU_o_valid, IDU_o_ready); end
    WB_i_retire = 1; #1;
    checks++; if (IDU_o_valid !== 1'b0) begin errors++; $display("FAIL full_same_cycle got %b exp 0", IDU_o_valid); end
    tick(); WB_i_retire = 0; #1;
    checks++; if (IDU_o_inflight !== 3 || IDU_o_valid !== 1'b1) begin errors++; $display("FAIL full_resume got %0d/%b exp 3/1", IDU_o_inflight, IDU_o_valid); end
    tick(); IDU_i_valid = 0; #1;
    checks++; if (IDU_o_inflight !== 4) begin errors++; $display("FAIL full_refill got %0d exp 4", IDU_o_inflight); end
    $display("full: inflight=%0d", IDU_o_inflight);
    WB_i_retire = 1; repeat (4) tick(); idle(); #1;
    checks++; if (IDU_o_inflight !== 0) begin errors++; $display("FAIL full_drain got %0d exp 0", IDU_o_inflight); end
  endtask

  task automatic test_serialize;
    IDU_i_valid = 1; repeat (2) tick();
    IDU_i_serialize = 1; #1;
    checks++; if (IDU_o_stall_ser !== 1'b1 || IDU_o_valid !== 1'b0) begin errors++; $display("FAIL ser_stall got %b/%b exp 1/0", IDU_o_stall_ser, IDU_o_valid); end
    tick(); WB_i_retire = 1; #1;
    checks++; if (IDU_o_valid !== 1'b0) begin errors++; $display("FAIL ser_first_retire got %b exp 0", IDU_o_valid); end
    tick();
`ifdef YSYX_23060136_SB_RETIRE_BYPASS_EN
    checks++; if (IDU_o_valid !== 1'b1) begin errors++; $display("FAIL ser_bypass got %b exp 1", IDU_o_valid); end
    tick(); idle();
`else
    checks++; if (IDU_o_valid !== 1'b0) begin errors++; $display("FAIL ser_nobypass got %b exp 0", IDU_o_valid); end
    tick(); WB_i_retire = 0; #1;
    checks++; if (IDU_o_inflight !== 0 || IDU_o_valid !== 1'b1 || IDU_o_stall_ser !== 1'b0) begin errors++; $display("FAIL ser_release got %0d/%b/%b exp 0/1/0", IDU_o_inflight, IDU_o_valid, IDU_o_stall_ser); end
    tick(); idle();
`endif
    #1;
    checks++; if (IDU_o_inflight !== 1) begin errors++; $display("FAIL ser_issued got %0d exp 1", IDU_o_inflight); end
    $display("serialize: issued after drain, inflight=%0d", IDU_o_inflight);
    WB_i_retire = 1; tick(); idle();
  endtask

  task automatic test_same_cycle;
    IDU_i_valid = 1; IDU_i_write_gpr = 1; IDU_i_rd = 7; tick();
    WB_i_retire = 1; WB_i_RegWr = 1; WB_i_rd = 7; tick(); idle(); #1;
    checks++; if (IDU_o_inflight !== 1) begin errors++; $display("FAIL same_inflight got %0d exp 1", IDU_o_inflight); end
    IDU_i_valid = 1; IDU_i_use_rs2 = 1; IDU_i_rs2 = 7; #1;
    checks++; if (IDU_o_stall_raw !== 1'b1) begin errors++; $display("FAIL same_cnt_kept got %b exp 1", IDU_o_stall_raw); end
    IDU_i_valid = 0;
    WB_i_retire = 1; WB_i_RegWr = 1; WB_i_rd = 7; tick(); idle();
    IDU_i_valid = 1; IDU_i_use_rs2 = 1; IDU_i_rs2 = 7; #1;
    checks++; if (IDU_o_stall_raw !== 1'b0 || IDU_o_inflight !== 0) begin errors++; $display("FAIL same_cleared got %b/%0d exp 0/0", IDU_o_stall_raw, IDU_o_inflight); end
    idle(); IDU_i_valid = 1; IDU_i_write_gpr = 1; IDU_i_rd = 0; tick(); idle();
    WB_i_retire = 1; WB_i_RegWr = 1; WB_i_rd = 0; tick(); idle(); #1;
    checks++; if (IDU_o_sb_err !== 1'b0 || IDU_o_inflight !== 0) begin errors++; $display("FAIL x0_untracked got %b/%0d exp 0/0", IDU_o_sb_err, IDU_o_inflight); end
    $display("same-cycle: inflight=%0d err=%b", IDU_o_inflight, IDU_o_sb_err);
  endtask

  task automatic test_halt_err;
    IDU_i_valid = 1; tick();
    IDU_i_system_halt = 1; #1;
    checks++; if (IDU_o_valid !== 1'b1) begin errors++; $display("FAIL halt_issue got %b exp 1", IDU_o_valid); end
    tick(); IDU_i_system_halt = 0; #1;
    checks++; if (IDU_o_inflight !== 2 || IDU_o_valid !== 1'b0 || IDU_o_halted !== 1'b0) begin errors++; $display("FAIL halt_block got %0d/%b/%b exp 2/0/0", IDU_o_inflight, IDU_o_valid, IDU_o_halted); end
    WB_i_retire = 1; tick();
    checks++; if (IDU_o_halted !== 1'b0) begin errors++; $display("FAIL halt_early got %b exp 0", IDU_o_halted); end
    tick(); WB_i_retire = 0; #1;
    checks++; if (IDU_o_halted !== 1'b1 || IDU_o_valid !== 1'b0 || IDU_o_sb_err !== 1'b0) begin errors++; $display("FAIL halt_done got %b/%b/%b exp 1/0/0", IDU_o_halted, IDU_o_valid, IDU_o_sb_err); end
    WB_i_retire = 1; tick(); WB_i_retire = 0; #1;
    checks++; if (IDU_o_sb_err !== 1'b1 || IDU_o_inflight !== 0) begin errors++; $display("FAIL err_set got %b/%0d exp 1/0", IDU_o_sb_err, IDU_o_inflight); end
    tick();
    checks++; if (IDU_o_sb_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", IDU_o_sb_err); end
    $display("halt: halted=%b err=%b", IDU_o_halted, IDU_o_sb_err);
    rst = 0; #1;
    checks++; if (IDU_o_sb_err !== 1'b0 || IDU_o_valid !== 1'b1 || IDU_o_halted !== 1'b0) begin errors++; $display("FAIL err_reset got %b/%b/%b exp 0/1/0", IDU_o_sb_err, IDU_o_valid, IDU_o_halted); end
    tick(); idle(); rst = 1; tick();
  endtask

  // Reference: the in-flight instructions as an in-order queue. Pending
  // writes to a register are the queue entries that write it; the oldest
  // entry is the one that retires.
  task automatic test_random;
    ent_t q[$];
    int   pend[32];
    int   infl_eff, bad;
    bit   raw, full, ser, blk, ret, iss;
    for (int cyc = 0; cyc < 500; cyc++) begin
      idle();
      IDU_i_valid     = ($urandom_range(0, 3) != 0);
      IDU_i_rs1       = 5'($urandom_range(0, 7));
      IDU_i_rs2       = 5'($urandom_range(0, 7));
      IDU_i_use_rs1   = 1'($urandom);
      IDU_i_use_rs2   = 1'($urandom);
      IDU_i_rd        = 5'($urandom_range(0, 7));
      IDU_i_write_gpr = 1'($urandom);
      IDU_i_serialize = ($urandom_range(0, 7) == 0);
      EXU_i_ready     = ($urandom_range(0, 4) != 0);
      ret = (q.size() > 0) && ($urandom_range(0, 2) == 0);
      WB_i_retire = ret;
      if (ret) begin WB_i_rd = q[0].rd; WB_i_RegWr = q[0].w; end

      for (int r = 0; r < 32; r++) pend[r] = 0;
      foreach (q[i]) if (q[i].w && q[i].rd != 0) pend[q[i].rd]++;
      infl_eff = q.size();
`ifdef YSYX_23060136_SB_RETIRE_BYPASS_EN
      if (ret) begin
        infl_eff--;
        if (q[0].w && q[0].rd != 0) pend[q[0].rd]--;
      end
`endif
      raw  = (IDU_i_use_rs1 && IDU_i_rs1 != 0 && pend[IDU_i_rs1] > 0) ||
             (IDU_i_use_rs2 && IDU_i_rs2 != 0 && pend[IDU_i_rs2] > 0);
      full = (q.size() == DEPTH);
      ser  = IDU_i_serialize && infl_eff != 0;
      blk  = raw || full || ser;
      iss  = IDU_i_valid && !blk && EXU_i_ready;
      #1;
      bad = 0;
      checks++; if (IDU_o_valid !== (IDU_i_valid && !blk)) begin errors++; bad = 1; $display("FAIL rnd_valid cyc %0d got %b exp %b", cyc, IDU_o_valid, IDU_i_valid && !blk); end
      checks++; if (IDU_o_ready !== (!blk && EXU_i_ready)) begin errors++; bad = 1; $display("FAIL rnd_ready cyc %0d got %b exp %b", cyc, IDU_o_ready, !blk && EXU_i_ready); end
      checks++; if ({IDU_o_stall_raw, IDU_o_stall_full, IDU_o_stall_ser} !== {raw && IDU_i_valid, full && IDU_i_valid, ser && IDU_i_valid}) begin errors++; bad = 1; $display("FAIL rnd_stall cyc %0d got %b%b%b exp %b%b%b", cyc, IDU_o_stall_raw, IDU_o_stall_full, IDU_o_stall_ser, raw && IDU_i_valid, full && IDU_i_valid, ser && IDU_i_valid); end
      checks++; if (IDU_o_inflight !== CNT_W'(q.size()) || IDU_o_sb_err !== 1'b0 || IDU_o_halted !== 1'b0) begin errors++; bad = 1; $display("FAIL rnd_state cyc %0d got %0d/%b/%b exp %0d/0/0", cyc, IDU_o_inflight, IDU_o_sb_err, IDU_o_halted, q.size()); end
      if (cyc % 50 == 0) $display("rnd cyc %0d inflight=%0d issue=%b retire=%b", cyc, q.size(), iss, ret);
      tick();
      if (ret) void'(q.pop_front());
      if (iss) q.push_back('{w: IDU_i_write_gpr, rd: IDU_i_rd});
      if (bad != 0 && errors > 20) break;
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 0;
    test_reset();
    test_basic_issue();
    test_raw();
    test_full();
    test_serialize();
    test_same_cycle();
    test_halt_err();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
